instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetches 16-bit instructions for the RISC CPU core from byte-wide program memory. Each instruction takes two sequential reads on the shared memory bus, high byte first. The unit owns the program counter and presents the assembled opcode/operand address to the decode/control stage through a valid/ready handshake. It sits between the address-decoded ROM/RAM bus and the CPU controller, and it absorbs jump, skip and halt requests from the controller.

## Interface
- `DATA_W`, 8: memory bus width in bits.
- `ADDR_W`, 13: byte address width; also the operand width.
- `OP_W`, 3: opcode width. Requires `OP_W + ADDR_W == 2*DATA_W`.
- `RESET_PC`, 0: program counter value after reset.

- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd`  out  1  memory read strobe.
- `addr`  out  ADDR_W  memory byte address; equals `pc_addr`.
- `mem_data`  in  DATA_W  read data, valid the cycle after `rd`.
- `fetch`  out  1  high while any read of the current instruction is in progress.
- `ir_valid`  out  1  the instruction outputs hold a complete instruction.
- `ir_ready`  in  1  the controller accepts the instruction.
- `opcode`  out  OP_W  `hi[DATA_W-1 -: OP_W]`.
- `ir_addr`  out  ADDR_W  `{hi[DATA_W-OP_W-1:0], lo}`.
- `pc_addr`  out  ADDR_W  current program counter.
- `skip`  in  1  qualified by the handshake: skip the next instruction.
- `jump`  in  1  redirect request; sampled in any state.
- `jump_addr`  in  ADDR_W  redirect target.
- `halt`  in  1  stop fetching.
- `halted`  out  1  high in the HALTED state.

## Operation
- States: IDLE, REQ_HI, WAIT_HI, REQ_LO, WAIT_LO, VALID, HALTED.
- IDLE always goes to REQ_HI.
- REQ_HI:
  - If `halt` is high, go to HALTED.
  - Otherwise drive `rd=1` with `addr=pc` and go to WAIT_HI.
- WAIT_HI: capture `mem_data` into `hi`, set `pc <= pc+1`, go to REQ_LO.
- REQ_LO: drive `rd=1` and go to WAIT_LO.
- WAIT_LO: capture `lo`, set `pc <= pc+1`, go to VALID.
- VALID:
  - `ir_valid=1`.
  - On `ir_ready`, go to REQ_HI, and set `pc <= pc+2` if `skip` is high.
  - `opcode` and `ir_addr` stay stable until accepted.
- HALTED: `rd=0`, `fetch=0`, `halted=1`. Only `rst` or `jump` leave this state.
- `rd` and `fetch` are decoded from the state:
  - `rd` is high in REQ_HI and REQ_LO.
  - `fetch` is high in REQ_HI, WAIT_HI, REQ_LO and WAIT_LO.
- Priority: `rst` > `jump` > `skip`/handshake > `halt`.
- Jump behaviour:
  - Sets `pc <= jump_addr`, next state REQ_HI, and `ir_valid` drops the following cycle.
  - Any partially captured bytes are discarded.
  - A jump in VALID coincident with `ir_ready`: the current instruction is accepted, `skip` is ignored, and the new PC is `jump_addr`.
- `halt` is sampled only in REQ_HI. An in-flight fetch completes and is delivered first.
- PC arithmetic is modulo 2^ADDR_W. A low byte at `2^ADDR_W-1` wraps to 0, and `skip` wraps the same way.

## Timing
- Reset values:
  - state IDLE, `pc=RESET_PC`, `hi=lo=0`.
  - Outputs: `rd=0`, `fetch=0`, `ir_valid=0`, `halted=0`, `opcode=0`, `ir_addr=0`, `addr=pc_addr=RESET_PC`.
- `rst` asserted in any state forces the reset values at the next edge. A fetch in progress is abandoned.
- First clock edge with `rst=0`: IDLE→REQ_HI, so `rd` is high in the second cycle after reset release.
- Fetch latency: REQ_HI cycle to `ir_valid` high is 4 cycles.
- Throughput with `ir_ready` held high is one instruction per 5 cycles.
- Memory contract: the memory samples `addr` while `rd` is high and drives `mem_data` throughout the next cycle. The unit samples `mem_data` at the end of WAIT_* cycles.
- Jump: the REQ_HI cycle follows the `jump` cycle immediately, with `addr=jump_addr`.

## Structure
- The shared header `cpu_defs.vh` holds:
  - the state encoding, with localparams `S_IDLE` … `S_HALTED`;
  - the opcode constants `HLT`, `SKZ`, `ADD`, `AND`, `XOR`, `LDA`, `STO`, `JMP`;
  - the default widths.
- One sub-module: `pc_counter`, holding the ADDR_W register with load, +1 and +2 controls, and wraparound.
- The FSM and the instruction registers stay in `instr_fetch_unit`.

## Test plan
- Reset then fetch; memory holds `0xA0 0x05` at 0 and 1 → `rd` at addresses 0 then 1, `ir_valid` 4 cycles after the first REQ_HI, `opcode=5`, `ir_addr=0x0005`, `pc_addr=2`.
- Backpressure: hold `ir_ready=0` for 10 cycles → `ir_valid` stays high, outputs are stable, no `rd`, `pc` stays 2.
- Jump in WAIT_LO with `jump_addr=0x0100` → next cycle REQ_HI with `addr=0x0100`; the old instruction is never presented.
- Skip on acceptance at `pc=2` → next fetch reads addresses 4 and 5.
- Halt: `halt=1` in REQ_HI → HALTED, `halted=1`, no `rd` for 20 cycles. A later `jump` with `jump_addr=0x10` resumes at address 0x10.
- Wraparound: `RESET_PC=0x1FFF` → reads 0x1FFF then 0x0000, and `pc_addr=1` after the instruction.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// fetch FSM state encoding and the CPU opcode set.
package instr_fetch_unit_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 13;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_HI,
        S_WAIT_HI,
        S_REQ_LO,
        S_WAIT_LO,
        S_VALID,
        S_HALTED
    } state_e;

    typedef enum logic [2:0] {
        HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
    } opcode_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory bus plus controller handshake seen by the fetch unit.
// The master modport is the fetch unit; slave is the memory/controller side.
interface instr_fetch_unit_if #(
    parameter int DATA_W = instr_fetch_unit_pkg::DATA_W_DEF,
    parameter int ADDR_W = instr_fetch_unit_pkg::ADDR_W_DEF,
    parameter int OP_W   = instr_fetch_unit_pkg::OP_W_DEF
);
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_data;
    logic              fetch;
    logic              ir_valid;
    logic              ir_ready;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic              skip;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;
    logic              halted;

    modport master (
        output rd, addr, fetch, ir_valid, opcode, ir_addr, pc_addr, halted,
        input  mem_data, ir_ready, skip, jump, jump_addr, halt
    );

    modport slave (
        input  rd, addr, fetch, ir_valid, opcode, ir_addr, pc_addr, halted,
        output mem_data, ir_ready, skip, jump, jump_addr, halt
    );
endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: load beats +2 beats +1; arithmetic wraps modulo 2^ADDR_W.
module instr_fetch_unit_pc_counter #(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc1_i,
    input  logic              inc2_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = load_val_i;
        else if (inc2_i)
            pc_d = pc_q + ADDR_W'(2);
        else if (inc1_i)
            pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Two-read instruction fetch (high byte first) with valid/ready delivery,
// jump redirect, skip-on-accept and halt.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                OP_W     = OP_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                clk_i,
    input logic                rst_i,
    instr_fetch_unit_if.master bus_io
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              pc_load, pc_inc1, pc_inc2;
    logic [ADDR_W-1:0] pc;

    instr_fetch_unit_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (pc_load),
        .load_val_i (bus_io.jump_addr),
        .inc1_i     (pc_inc1),
        .inc2_i     (pc_inc2),
        .pc_o       (pc)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pc_load = 1'b0;
        pc_inc1 = 1'b0;
        pc_inc2 = 1'b0;
        // A jump overrides whatever the FSM was doing; half-fetched bytes are dropped.
        if (bus_io.jump) begin
            pc_load = 1'b1;
            state_d = S_REQ_HI;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_REQ_HI;
                S_REQ_HI:  state_d = bus_io.halt ? S_HALTED : S_WAIT_HI;
                S_WAIT_HI: begin
                    hi_d    = bus_io.mem_data;
                    pc_inc1 = 1'b1;
                    state_d = S_REQ_LO;
                end
                S_REQ_LO:  state_d = S_WAIT_LO;
                S_WAIT_LO: begin
                    lo_d    = bus_io.mem_data;
                    pc_inc1 = 1'b1;
                    state_d = S_VALID;
                end
                S_VALID: begin
                    if (bus_io.ir_ready) begin
                        pc_inc2 = bus_io.skip;
                        state_d = S_REQ_HI;
                    end
                end
                S_HALTED:  state_d = S_HALTED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus_io.rd       = (state_q == S_REQ_HI) || (state_q == S_REQ_LO);
    assign bus_io.fetch    = (state_q == S_REQ_HI) || (state_q == S_WAIT_HI) ||
                             (state_q == S_REQ_LO) || (state_q == S_WAIT_LO);
    assign bus_io.ir_valid = (state_q == S_VALID);
    assign bus_io.halted   = (state_q == S_HALTED);
    assign bus_io.addr     = pc;
    assign bus_io.pc_addr  = pc;
    assign bus_io.opcode   = hi_q[DATA_W-1 -: OP_W];
    assign bus_io.ir_addr  = {hi_q[DATA_W-OP_W-1:0], lo_q};
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized accept/skip/jump
// traffic, checked against an address-level model of the program counter.
module tb_instr_fetch_unit;
    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int OW    = 3;
    localparam int MEMSZ = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) bus_a ();
    instr_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) bus_b ();

    instr_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .RESET_PC(13'h0000)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus_io(bus_a)
    );
    instr_fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .RESET_PC(13'h1FFF)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus_io(bus_b)
    );

    logic [DW-1:0] mem [MEMSZ];
    logic [AW-1:0] qa [$];
    logic [AW-1:0] qb [$];
    int n_cmp = 0;
    int n_bad = 0;
    int pc_m;

    // Memory answers during the cycle after rd; junk otherwise. Every read address is logged.
    always @(posedge clk) begin
        if (bus_a.rd) begin
            bus_a.mem_data <= mem[bus_a.addr];
            qa.push_back(bus_a.addr);
        end else bus_a.mem_data <= 8'($urandom);
        if (bus_b.rd) begin
            bus_b.mem_data <= mem[bus_b.addr];
            qb.push_back(bus_b.addr);
        end else bus_b.mem_data <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_op(input int a);
        logic [DW-1:0] b;
        b = mem[a % MEMSZ];
        return 32'(b[DW-1 -: OW]);
    endfunction

    function automatic logic [31:0] exp_ir(input int a);
        logic [DW-1:0] h;
        h = mem[a % MEMSZ];
        return 32'({h[DW-OW-1:0], mem[(a + 1) % MEMSZ]});
    endfunction

    // Called at the negedge of a REQ_HI cycle; waits for the instruction and checks it.
    task automatic fetch_a(input string tag);
        int lat;
        int a;
        a = pc_m;
        qa.delete();
        chk({tag, ".rd"},    32'(bus_a.rd), 1);
        chk({tag, ".addr"},  32'(bus_a.addr), a);
        chk({tag, ".fetch"}, 32'(bus_a.fetch), 1);
        chk({tag, ".nvld"},  32'(bus_a.ir_valid), 0);
        lat = 0;
        while (!bus_a.ir_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"},   lat, 4);
        chk({tag, ".nrd"},   qa.size(), 2);
        chk({tag, ".rd0"},   qa.size() > 0 ? 32'(qa[0]) : 32'hDEAD, a);
        chk({tag, ".rd1"},   qa.size() > 1 ? 32'(qa[1]) : 32'hDEAD, (a + 1) % MEMSZ);
        chk({tag, ".op"},    32'(bus_a.opcode), exp_op(a));
        chk({tag, ".ira"},   32'(bus_a.ir_addr), exp_ir(a));
        pc_m = (a + 2) % MEMSZ;
        chk({tag, ".pc"},    32'(bus_a.pc_addr), pc_m);
    endtask

    // Called at a VALID negedge; ends at the negedge of the following REQ_HI.
    task automatic accept_a(input bit s, input bit j, input int ja);
        bus_a.ir_ready  = 1'b1;
        bus_a.skip      = s;
        bus_a.jump      = j;
        bus_a.jump_addr = AW'(ja);
        @(negedge clk);
        bus_a.ir_ready = 1'b0;
        bus_a.skip     = 1'b0;
        bus_a.jump     = 1'b0;
        pc_m = j ? ja : (pc_m + (s ? 2 : 0)) % MEMSZ;
    endtask

    // From a REQ_HI negedge, jump k cycles into the fetch (k=3 lands in WAIT_LO).
    task automatic jump_mid(input int k, input int ja);
        repeat (k) @(negedge clk);
        bus_a.jump      = 1'b1;
        bus_a.jump_addr = AW'(ja);
        @(negedge clk);
        bus_a.jump = 1'b0;
        pc_m = ja;
    endtask

    initial begin
        logic [OW-1:0] op_s;
        logic [AW-1:0] ir_s;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA0;
        mem[1] = 8'h05;
        rst = 1'b1;
        bus_a.ir_ready = 1'b0; bus_a.skip = 1'b0; bus_a.jump = 1'b0;
        bus_a.jump_addr = '0;  bus_a.halt = 1'b0;
        bus_b.ir_ready = 1'b0; bus_b.skip = 1'b0; bus_b.jump = 1'b0;
        bus_b.jump_addr = '0;  bus_b.halt = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst.rd",     32'(bus_a.rd), 0);
        chk("rst.fetch",  32'(bus_a.fetch), 0);
        chk("rst.vld",    32'(bus_a.ir_valid), 0);
        chk("rst.halted", 32'(bus_a.halted), 0);
        chk("rst.op",     32'(bus_a.opcode), 0);
        chk("rst.ira",    32'(bus_a.ir_addr), 0);
        chk("rst.pc",     32'(bus_a.pc_addr), 0);
        chk("rst.addr",   32'(bus_a.addr), 0);
        chk("rstb.pc",    32'(bus_b.pc_addr), 32'h1FFF);

        rst = 1'b0;
        qb.delete();
        chk("rel.nrd", 32'(bus_a.rd), 0);
        @(negedge clk);
        pc_m = 0;
        fetch_a("first");
        chk("first.op5",   32'(bus_a.opcode), 5);
        chk("first.ira5",  32'(bus_a.ir_addr), 32'h0005);
        chk("first.pc2",   32'(bus_a.pc_addr), 2);

        chk("wrap.vld",  32'(bus_b.ir_valid), 1);
        chk("wrap.nrd",  qb.size(), 2);
        chk("wrap.rd0",  qb.size() > 0 ? 32'(qb[0]) : 32'hDEAD, 32'h1FFF);
        chk("wrap.rd1",  qb.size() > 1 ? 32'(qb[1]) : 32'hDEAD, 0);
        chk("wrap.pc",   32'(bus_b.pc_addr), 1);
        chk("wrap.op",   32'(bus_b.opcode), exp_op(32'h1FFF));
        chk("wrap.ira",  32'(bus_b.ir_addr), exp_ir(32'h1FFF));

        op_s = bus_a.opcode;
        ir_s = bus_a.ir_addr;
        qa.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.vld", 32'(bus_a.ir_valid), 1);
            chk("bp.op",  32'(bus_a.opcode), 32'(op_s));
            chk("bp.ira", 32'(bus_a.ir_addr), 32'(ir_s));
            chk("bp.pc",  32'(bus_a.pc_addr), 2);
            chk("bp.rd",  32'(bus_a.rd), 0);
        end
        chk("bp.nrd", qa.size(), 0);

        accept_a(1'b1, 1'b0, 0);
        chk("skip.pc4", pc_m, 4);
        fetch_a("skip");

        accept_a(1'b0, 1'b0, 0);
        jump_mid(3, 32'h0100);
        fetch_a("jump");

        // Jump together with accept and skip: skip must be ignored.
        accept_a(1'b1, 1'b1, 32'h1FFC);
        fetch_a("jacc");
        accept_a(1'b1, 1'b0, 0);
        chk("skipwrap", pc_m, 0);
        fetch_a("skipwrap");

        accept_a(1'b0, 1'b0, 0);
        bus_a.halt = 1'b1;
        @(negedge clk);
        bus_a.halt = 1'b0;
        qa.delete();
        for (int i = 0; i < 20; i++) begin
            chk("halt.h",  32'(bus_a.halted), 1);
            chk("halt.rd", 32'(bus_a.rd), 0);
            chk("halt.f",  32'(bus_a.fetch), 0);
            @(negedge clk);
        end
        chk("halt.nrd", qa.size(), 0);
        bus_a.jump      = 1'b1;
        bus_a.jump_addr = 13'h0010;
        @(negedge clk);
        bus_a.jump = 1'b0;
        pc_m = 32'h10;
        chk("resume.h", 32'(bus_a.halted), 0);
        fetch_a("resume");

        for (int it = 0; it < 25; it++) begin
            int bp;
            bp = int'($urandom_range(0, 3));
            repeat (bp) begin
                @(negedge clk);
                chk("rnd.hold", 32'(bus_a.ir_valid), 1);
            end
            if ($urandom_range(0, 3) == 0)
                accept_a(1'($urandom), 1'b1, int'($urandom_range(0, MEMSZ - 1)));
            else
                accept_a(1'($urandom), 1'b0, 0);
            if ($urandom_range(0, 3) == 0)
                jump_mid(int'($urandom_range(0, 3)), int'($urandom_range(0, MEMSZ - 1)));
            fetch_a("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
